// File: rtl/ma_mem_responder_if.sv
// MA-stage memory request bus: level read/write requests with four-phase acks.
// Ports: co_re/co_we, lengths, byte addresses, write data, read data, acks.
interface ma_mem_responder_if #(
    parameter int MADDR_L = 32,
    parameter int DATA_L  = 32
);
    logic               co_re;
    logic               co_we;
    logic [1:0]         co_rlen;
    logic [1:0]         co_wlen;
    logic [MADDR_L-1:0] m_raddr;
    logic [MADDR_L-1:0] m_waddr;
    logic [DATA_L-1:0]  mem_out;
    logic [DATA_L-1:0]  mem_in;
    logic               co_rack;
    logic               co_wack;

    modport master (
        output co_re, co_we, co_rlen, co_wlen,
        output m_raddr, m_waddr, mem_out,
        input  mem_in, co_rack, co_wack
    );

    modport slave (
        input  co_re, co_we, co_rlen, co_wlen,
        input  m_raddr, m_waddr, mem_out,
        output mem_in, co_rack, co_wack
    );
endinterface

// File: rtl/ma_mem_responder.sv
// Memory-side responder: serialises MA byte/half/word requests onto a byte RAM.
// Ports: clk, rst (sync, active-low), ma (slave bus), ram_en/we/addr/wdata/rdata.
module ma_mem_responder #(
    parameter int MADDR_L = 32,
    parameter int DATA_L  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    ma_mem_responder_if.slave  ma,
    output logic               ram_en,
    output logic               ram_we,
    output logic [MADDR_L-1:0] ram_addr,
    output logic [7:0]         ram_wdata,
    input  logic [7:0]         ram_rdata
);

    localparam int WW = $clog2(RAM_LAT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISS,
        S_RD_CAP,
        S_WR,
        S_ACK_R,
        S_ACK_W
    } state_t;

    state_t             state_q, state_d;
    logic [MADDR_L-1:0] base_q, base_d;
    logic [2:0]         n_q, n_d;
    logic [1:0]         k_q, k_d;
    logic [DATA_L-1:0]  wd_q, wd_d;
    logic [DATA_L-1:0]  sh_q, sh_d;
    logic [WW-1:0]      wt_q, wt_d;
    logic [DATA_L-1:0]  mem_in_q, mem_in_d;
    logic               rack_q, rack_d;
    logic               wack_q, wack_d;
    // Reserved-length request accepted: ack on the following edge, no RAM use.
    logic               rsv_q, rsv_d;
    logic               rsvw_q, rsvw_d;
    logic               last;

    function automatic logic [2:0] len_n(input logic [1:0] l);
        case (l)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            2'b11:   return 3'd4;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [DATA_L-1:0] lane_mask(input logic [2:0] n);
        case (n)
            3'd1:    return DATA_L'(32'h0000_00FF);
            3'd2:    return DATA_L'(32'h0000_FFFF);
            default: return '1;
        endcase
    endfunction

    assign ma.mem_in  = mem_in_q;
    assign ma.co_rack = rack_q;
    assign ma.co_wack = wack_q;

    assign last = (3'(k_q) == (n_q - 3'd1));

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        n_d       = n_q;
        k_d       = k_q;
        wd_d      = wd_q;
        sh_d      = sh_q;
        wt_d      = wt_q;
        mem_in_d  = mem_in_q;
        rack_d    = rack_q;
        wack_d    = wack_q;
        rsv_d     = rsv_q;
        rsvw_d    = rsvw_q;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = base_q + MADDR_L'(k_q);
        ram_wdata = wd_q[{k_q, 3'b000} +: 8];

        unique case (state_q)
            S_IDLE: begin
                if (rsv_q) begin
                    rsv_d = 1'b0;
                    if (rsvw_q) begin
                        wack_d  = 1'b1;
                        state_d = S_ACK_W;
                    end else begin
                        rack_d   = 1'b1;
                        mem_in_d = '0;
                        state_d  = S_ACK_R;
                    end
                end else if (ma.co_we) begin
                    base_d = ma.m_waddr;
                    n_d    = len_n(ma.co_wlen);
                    k_d    = 2'd0;
                    wd_d   = ma.mem_out;
                    if (len_n(ma.co_wlen) == 3'd0) begin
                        rsv_d  = 1'b1;
                        rsvw_d = 1'b1;
                    end else begin
                        state_d = S_WR;
                    end
                end else if (ma.co_re) begin
                    base_d = ma.m_raddr;
                    n_d    = len_n(ma.co_rlen);
                    k_d    = 2'd0;
                    sh_d   = '0;
                    if (len_n(ma.co_rlen) == 3'd0) begin
                        rsv_d  = 1'b1;
                        rsvw_d = 1'b0;
                    end else begin
                        state_d = S_RD_ISS;
                    end
                end
            end
            S_RD_ISS: begin
                ram_en  = 1'b1;
                wt_d    = WW'(RAM_LAT);
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                if (wt_q == WW'(1)) begin
                    sh_d[{k_q, 3'b000} +: 8] = ram_rdata;
                    if (last) begin
                        mem_in_d = sh_d & lane_mask(n_q);
                        rack_d   = 1'b1;
                        state_d  = S_ACK_R;
                    end else begin
                        k_d     = k_q + 2'd1;
                        state_d = S_RD_ISS;
                    end
                end else begin
                    wt_d = wt_q - WW'(1);
                end
            end
            S_WR: begin
                ram_en = 1'b1;
                ram_we = 1'b1;
                if (last) begin
                    wack_d  = 1'b1;
                    state_d = S_ACK_W;
                end else begin
                    k_d = k_q + 2'd1;
                end
            end
            S_ACK_R: begin
                if (!ma.co_re) begin
                    rack_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_ACK_W: begin
                if (!ma.co_we) begin
                    wack_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            n_q      <= '0;
            k_q      <= '0;
            wd_q     <= '0;
            sh_q     <= '0;
            wt_q     <= '0;
            mem_in_q <= '0;
            rack_q   <= 1'b0;
            wack_q   <= 1'b0;
            rsv_q    <= 1'b0;
            rsvw_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            n_q      <= n_d;
            k_q      <= k_d;
            wd_q     <= wd_d;
            sh_q     <= sh_d;
            wt_q     <= wt_d;
            mem_in_q <= mem_in_d;
            rack_q   <= rack_d;
            wack_q   <= wack_d;
            rsv_q    <= rsv_d;
            rsvw_q   <= rsvw_d;
        end
    end

endmodule
